// File: rtl/overall_edge_det.sv
// overall_edge_det: Sobel |Gx|+|Gy| edge magnitude over two overlapping 3x3 windows of a 3x4 pixel block.
module overall_edge_det (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [95:0] data_buffer,
  input  logic        shift_enable_r,
  input  logic        transfer_data_complete_r,
  input  logic        transfer_data_complete_w,
  output logic [7:0]  final_out_1,
  output logic [7:0]  final_out_2,
  output logic        buffer_clear
);
  typedef enum logic [2:0] {IDLE, WAIT_R, GX, GY, MAG, DONE, CLEAR} state_t;
  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [11:0][7:0]  w_q, w_d;
  logic signed [10:0] gx1_q, gx1_d, gx2_q, gx2_d, gy1_q, gy1_d, gy2_q, gy2_d;
  logic [7:0]        out1_q, out1_d, out2_q, out2_d;
  logic              clr_q, clr_d;
  function automatic logic signed [10:0] sob(input logic [7:0] a, b, c, d, e, f);
    logic [10:0] p, n;
    p = {3'b0, a} + {2'b0, b, 1'b0} + {3'b0, c};
    n = {3'b0, d} + {2'b0, e, 1'b0} + {3'b0, f};
    return signed'(p - n);
  endfunction
  // Gradients never reach -1024, so negation cannot overflow 11 bits.
  function automatic logic [7:0] mag(input logic signed [10:0] x, y);
    logic [10:0] ax, ay;
    logic [11:0] s;
    ax = x[10] ? 11'(-x) : 11'(x);
    ay = y[10] ? 11'(-y) : 11'(y);
    s = {1'b0, ax} + {1'b0, ay};
    return s > 12'd255 ? 8'hff : s[7:0];
  endfunction
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    w_d = w_q;
    gx1_d = gx1_q;
    gx2_d = gx2_q;
    gy1_d = gy1_q;
    gy2_d = gy2_q;
    out1_d = out1_q;
    out2_d = out2_q;
    case (state_q)
      IDLE: if (shift_enable_r) begin
        w_d = data_buffer;
        cnt_d = 2'd0;
        state_d = WAIT_R;
      end
      WAIT_R: if (transfer_data_complete_r) begin
        cnt_d = cnt_q + 2'd1;
        state_d = cnt_q == 2'd2 ? GX : WAIT_R;
      end
      GX: begin
        gx1_d = sob(w_q[2], w_q[6], w_q[10], w_q[0], w_q[4], w_q[8]);
        gx2_d = sob(w_q[3], w_q[7], w_q[11], w_q[1], w_q[5], w_q[9]);
        state_d = GY;
      end
      GY: begin
        gy1_d = sob(w_q[8], w_q[9], w_q[10], w_q[0], w_q[1], w_q[2]);
        gy2_d = sob(w_q[9], w_q[10], w_q[11], w_q[1], w_q[2], w_q[3]);
        state_d = MAG;
      end
      MAG: begin
        out1_d = mag(gx1_q, gy1_q);
        out2_d = mag(gx2_q, gy2_q);
        state_d = DONE;
      end
      DONE: state_d = transfer_data_complete_w ? CLEAR : DONE;
      default: state_d = IDLE;
    endcase
    clr_d = state_d == CLEAR;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      w_q <= '0;
      gx1_q <= '0;
      gx2_q <= '0;
      gy1_q <= '0;
      gy2_q <= '0;
      out1_q <= '0;
      out2_q <= '0;
      clr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      w_q <= w_d;
      gx1_q <= gx1_d;
      gx2_q <= gx2_d;
      gy1_q <= gy1_d;
      gy2_q <= gy2_d;
      out1_q <= out1_d;
      out2_q <= out2_d;
      clr_q <= clr_d;
    end
  end
  assign final_out_1 = out1_q;
  assign final_out_2 = out2_q;
  assign buffer_clear = clr_q;
endmodule

// File: tb/tb_overall_edge_det.sv
// tb_overall_edge_det: directed and randomized frames checked against a kernel-convolution model.
module tb_overall_edge_det;
  typedef int arr12_t[12];
  logic        clk, n_rst, shift_enable_r, transfer_data_complete_r, transfer_data_complete_w;
  logic [95:0] data_buffer;
  logic [7:0]  final_out_1, final_out_2;
  logic        buffer_clear;
  int          vectors = 0, miscompares = 0;
  logic [7:0]  exp1, exp2;

  overall_edge_det dut (
    .clk(clk),
    .n_rst(n_rst),
    .data_buffer(data_buffer),
    .shift_enable_r(shift_enable_r),
    .transfer_data_complete_r(transfer_data_complete_r),
    .transfer_data_complete_w(transfer_data_complete_w),
    .final_out_1(final_out_1),
    .final_out_2(final_out_2),
    .buffer_clear(buffer_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [95:0] pk(input arr12_t b);
    logic [95:0] d;
    for (int k = 0; k < 12; k++) d[8*k +: 8] = 8'(b[k]);
    return d;
  endfunction

  function automatic void model(input logic [95:0] d, output logic [7:0] m1, output logic [7:0] m2);
    int kx[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    int ky[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
    int m[2];
    for (int off = 0; off < 2; off++) begin
      int gx = 0, gy = 0, p;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          p = int'(d[8*(4*r+c+off) +: 8]);
          gx += kx[r][c] * p;
          gy += ky[r][c] * p;
        end
      m[off] = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (m[off] > 255) m[off] = 255;
    end
    m1 = 8'(m[0]);
    m2 = 8'(m[1]);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic start(input logic [95:0] d);
    data_buffer = d;
    shift_enable_r = 1'b1;
    tick(1);
    shift_enable_r = 1'b0;
    data_buffer = {$urandom, $urandom, $urandom};
  endtask

  task automatic strobe(input int gap);
    tick(gap);
    transfer_data_complete_r = 1'b1;
    tick(1);
    transfer_data_complete_r = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input logic [7:0] e1, input logic [7:0] e2);
    tick(2);
    chk({tag, "_hold1"}, final_out_1, exp1);
    chk({tag, "_hold2"}, final_out_2, exp2);
    tick(1);
    chk({tag, "_out1"}, final_out_1, e1);
    chk({tag, "_out2"}, final_out_2, e2);
    chk({tag, "_noclr"}, {7'b0, buffer_clear}, 8'd0);
    exp1 = e1;
    exp2 = e2;
    transfer_data_complete_w = 1'b1;
    tick(1);
    chk({tag, "_clr"}, {7'b0, buffer_clear}, 8'd1);
    transfer_data_complete_w = 1'b0;
    tick(1);
    chk({tag, "_clr_end"}, {7'b0, buffer_clear}, 8'd0);
    chk({tag, "_keep1"}, final_out_1, e1);
  endtask

  task automatic run_frame(input string tag, input logic [95:0] d, input int gap, input logic [7:0] e1, input logic [7:0] e2);
    start(d);
    repeat (3) strobe(gap);
    finish_frame(tag, e1, e2);
  endtask

  initial begin
    logic [95:0] d29, d40, d200, d;
    logic [7:0] m1, m2;
    d29 = {{6{8'd200}}, {6{8'd100}}};
    d40 = {{4{8'd20}}, {8{8'd10}}};
    d200 = {{4{8'd50}}, {8{8'd0}}};
    n_rst = 1'b0;
    shift_enable_r = 1'b0;
    transfer_data_complete_r = 1'b0;
    transfer_data_complete_w = 1'b0;
    data_buffer = {$urandom, $urandom, $urandom};
    tick(2);
    chk("rst_out1", final_out_1, 8'd0);
    chk("rst_out2", final_out_2, 8'd0);
    chk("rst_clr", {7'b0, buffer_clear}, 8'd0);
    exp1 = 8'd0;
    exp2 = 8'd0;
    n_rst = 1'b1;
    transfer_data_complete_w = 1'b1;
    transfer_data_complete_r = 1'b1;
    tick(3);
    chk("idle_w_ignored", {7'b0, buffer_clear}, 8'd0);
    transfer_data_complete_w = 1'b0;
    transfer_data_complete_r = 1'b0;
    // Write-complete raised in GX and held: clear pulse follows first DONE cycle.
    start(d29);
    repeat (3) strobe(4);
    transfer_data_complete_w = 1'b1;
    tick(2);
    chk("sat_hold1", final_out_1, 8'd0);
    tick(1);
    chk("sat_out1", final_out_1, 8'd255);
    chk("sat_out2", final_out_2, 8'd255);
    chk("sat_done_noclr", {7'b0, buffer_clear}, 8'd0);
    tick(1);
    chk("sat_clr", {7'b0, buffer_clear}, 8'd1);
    tick(1);
    chk("sat_clr_end", {7'b0, buffer_clear}, 8'd0);
    chk("sat_keep1", final_out_1, 8'd255);
    chk("sat_keep2", final_out_2, 8'd255);
    transfer_data_complete_w = 1'b0;
    exp1 = 8'd255;
    exp2 = 8'd255;
    run_frame("mixed", pk('{135, 56, 48, 100, 50, 49, 10, 80, 165, 98, 70, 150}), 1, 8'd255, 8'd255);
    run_frame("flat", {12{8'd100}}, 2, 8'd0, 8'd0);
    run_frame("row40", d40, 0, 8'd40, 8'd40);
    // Two strobes only; a new shift with other data must not disturb the frame.
    start(d200);
    repeat (2) strobe(1);
    shift_enable_r = 1'b1;
    data_buffer = {12{8'd100}};
    tick(6);
    shift_enable_r = 1'b0;
    chk("wait2_out1", final_out_1, 8'd40);
    chk("wait2_out2", final_out_2, 8'd40);
    chk("wait2_clr", {7'b0, buffer_clear}, 8'd0);
    strobe(0);
    finish_frame("third", 8'd200, 8'd200);
    // Reset while in GY aborts without a clear pulse.
    start(d29);
    repeat (3) strobe(0);
    tick(1);
    n_rst = 1'b0;
    tick(1);
    chk("gyrst_out1", final_out_1, 8'd0);
    chk("gyrst_out2", final_out_2, 8'd0);
    chk("gyrst_clr", {7'b0, buffer_clear}, 8'd0);
    n_rst = 1'b1;
    exp1 = 8'd0;
    exp2 = 8'd0;
    transfer_data_complete_w = 1'b1;
    tick(4);
    chk("gyrst_noclr", {7'b0, buffer_clear}, 8'd0);
    transfer_data_complete_w = 1'b0;
    run_frame("after_rst", d40, 1, 8'd40, 8'd40);
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 12; k++)
        d[8*k +: 8] = (f % 2 == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      model(d, m1, m2);
      run_frame($sformatf("rand%0d", f), d, $urandom_range(0, 3), m1, m2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
